// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial arithmetic sequencers (adder now, multiplier/ALU later).
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_state_t;

    localparam int DEFAULT_WIDTH = 8;

    // A one-bit counter is still needed when only a single step is counted.
    function automatic int count_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Single full-adder cell, time-shared by the serial adder controller.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one fa_cell applied LSB first over WIDTH cycles, carry kept in a flip-flop.
// Optional subtract mode (port sub) is compiled in with `define SERIAL_ADD_SUB_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int            CW       = count_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    add_state_t       r_state;
    add_state_t       w_nextState;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_sumShift;
    logic             r_carry;

    logic [WIDTH-1:0] w_bIn;
    logic             w_carryIn;
    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_sumNext;
    logic             w_lastBit;

    // Subtraction is A + ~B + 1, so B is inverted and the carry forced at latch time.
`ifdef SERIAL_ADD_SUB_EN
    assign w_bIn     = sub ? ~b : b;
    assign w_carryIn = sub ? 1'b1 : cin;
`else
    assign w_bIn     = b;
    assign w_carryIn = cin;
`endif

    fa_cell u_fa (
        .x  (r_a[0]),
        .y  (r_b[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    assign w_sumNext = {w_s, r_sumShift};
    assign w_lastBit = (r_cnt == LAST_BIT);
    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = RUN;
            RUN:     if (w_lastBit) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Overflow is carry into MSB (still in r_carry) XOR carry out of MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_sumShift <= '0;
            r_carry    <= 1'b0;
            sum        <= '0;
            cout       <= 1'b0;
            overflow   <= 1'b0;
        end else if (r_state == IDLE) begin
            if (start) begin
                r_a     <= a;
                r_b     <= w_bIn;
                r_carry <= w_carryIn;
                r_cnt   <= '0;
            end
        end else if (r_state == RUN) begin
            r_sumShift <= w_sumNext[WIDTH-1:1];
            r_carry    <= w_co;
            r_a        <= r_a >> 1;
            r_b        <= r_b >> 1;
            r_cnt      <= r_cnt + 1'b1;
            if (w_lastBit) begin
                sum      <= w_sumNext;
                cout     <= w_co;
                overflow <= r_carry ^ w_co;
            end
        end
    end

endmodule
